// File: rtl/fwd_hazard_if.sv
// Decode-side bundle of the forwarding/hazard unit.
// master drives decode/redirect; slave returns selects, stall and counters.
interface fwd_hazard_if #(
  parameter int DEPTH = 3
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic            id_valid;
  logic [31:0]     id_inst;
  logic            redirect;
  logic            stall;
  logic [SELW-1:0] fwd_rs1_sel;
  logic [SELW-1:0] fwd_rs2_sel;
  logic [31:0]     stall_cycles;
  logic [31:0]     flush_cycles;

  modport master (
    output id_valid, id_inst, redirect,
    input  stall, fwd_rs1_sel, fwd_rs2_sel,
    input  stall_cycles, flush_cycles
  );

  modport slave (
    input  id_valid, id_inst, redirect,
    output stall, fwd_rs1_sel, fwd_rs2_sel,
    output stall_cycles, flush_cycles
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destinations, picks forwarding sources for decode
// and stalls on load-use hazards. Redirect kills decode over stall.
module fwd_hazard_unit #(
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  fwd_hazard_if.slave   bus
);
  localparam int SELW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       is_load;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_new;

  logic [4:0] op;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       wr_op;
  logic       use1;
  logic       use2;
  logic       is_ld;

  logic unused_bits;

  assign op  = bus.id_inst[6:2];
  assign rd  = bus.id_inst[11:7];
  assign rs1 = bus.id_inst[19:15];
  assign rs2 = bus.id_inst[24:20];

  assign unused_bits = ^{bus.id_inst[31:25],
                         bus.id_inst[14:12],
                         bus.id_inst[1:0]};

  always_comb begin
    wr_op = 1'b0;
    use1  = 1'b0;
    use2  = 1'b0;
    is_ld = 1'b0;
    unique case (1'b1)
      op == 5'd0: begin
        wr_op = 1'b1;
        use1  = 1'b1;
        is_ld = 1'b1;
      end
      op == 5'd8, op == 5'd24: begin
        use1 = 1'b1;
        use2 = 1'b1;
      end
      op == 5'd25, op == 5'd4: begin
        wr_op = 1'b1;
        use1  = 1'b1;
      end
      op == 5'd12: begin
        wr_op = 1'b1;
        use1  = 1'b1;
        use2  = 1'b1;
      end
      op == 5'd27, op == 5'd5, op == 5'd13: begin
        wr_op = 1'b1;
      end
      op == 5'd28: begin
        use1 = 1'b1;
      end
      default: ;
    endcase
  end

  logic [SELW-1:0] sel1;
  logic [SELW-1:0] sel2;
  logic            lu1;
  logic            lu2;
  logic            stall;

  // Scan oldest to youngest so the youngest match is the last to win.
  always_comb begin
    sel1 = '0;
    sel2 = '0;
    lu1  = 1'b0;
    lu2  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && ent_q[i].wr) begin
        if (use1 && ent_q[i].rd == rs1) begin
          sel1 = SELW'(i + 1);
          lu1  = ent_q[i].is_load && (i < LOAD_LAT);
        end
        if (use2 && ent_q[i].rd == rs2) begin
          sel2 = SELW'(i + 1);
          lu2  = ent_q[i].is_load && (i < LOAD_LAT);
        end
      end
    end
  end

  assign stall = (lu1 | lu2) & bus.id_valid & ~bus.redirect;

  assign bus.stall       = stall;
  assign bus.fwd_rs1_sel = stall ? '0 : sel1;
  assign bus.fwd_rs2_sel = stall ? '0 : sel2;

  always_comb begin
    ent_new.valid   = bus.id_valid & ~stall & ~bus.redirect;
    ent_new.rd      = rd;
    ent_new.wr      = wr_op & (rd != 5'd0);
    ent_new.is_load = is_ld;
  end

  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        ent_q[i] <= ent_q[i-1];
      end
      ent_q[0] <= ent_new;
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (bus.redirect && bus.id_valid) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_cycles = flush_cnt;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit (DEPTH=3, LOAD_LAT=1).
// Vectors run back to back; pipeline state carries between rows.
module tb_fwd_hazard_unit;
  logic clk;
  logic rst_n;

  fwd_hazard_if #(.DEPTH(3)) bus ();

  fwd_hazard_unit #(
    .DEPTH(3),
    .LOAD_LAT(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd,
                                        input logic [4:0] a,
                                        input logic [4:0] b);
    return {7'd0, b, a, 3'd0, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_addi(input logic [4:0] rd,
                                         input logic [4:0] a,
                                         input logic [11:0] imm);
    return {imm, a, 3'd0, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] i_lw(input logic [4:0] rd,
                                       input logic [4:0] a);
    return {12'd0, a, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] s_sw(input logic [4:0] b,
                                       input logic [4:0] a);
    return {7'd0, b, a, 3'b010, 5'd0, 7'b0100011};
  endfunction

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic        redir;
    logic        stall;
    int          s1;
    int          s2;
    int          stc;
    int          flc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic set_v(input int k, input logic v,
                       input logic [31:0] inst, input logic r,
                       input logic st, input int s1, input int s2,
                       input int stc, input int flc);
    vecs[k].valid = v;
    vecs[k].inst  = inst;
    vecs[k].redir = r;
    vecs[k].stall = st;
    vecs[k].s1    = s1;
    vecs[k].s2    = s2;
    vecs[k].stc   = stc;
    vecs[k].flc   = flc;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst,
                       input logic r);
    bus.id_valid = v;
    bus.id_inst  = inst;
    bus.redirect = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    drive(1'b0, 32'd0, 1'b0);

    // add dep chain
    set_v(0,  1, r_add(5, 1, 2),  0, 0, 0, 0, 0, 0);
    set_v(1,  1, r_add(6, 5, 5),  0, 0, 1, 1, 0, 0);
    set_v(2,  0, 32'd0,           0, 0, 0, 0, 0, 0);
    // load-use
    set_v(3,  1, i_lw(5, 1),      0, 0, 0, 0, 0, 0);
    set_v(4,  1, r_add(6, 5, 0),  0, 1, 0, 0, 0, 0);
    set_v(5,  1, r_add(6, 5, 0),  0, 0, 2, 0, 1, 0);
    set_v(6,  0, 32'd0,           0, 0, 0, 0, 1, 0);
    // x0 destination
    set_v(7,  1, i_addi(0, 1, 1), 0, 0, 0, 0, 1, 0);
    set_v(8,  1, r_add(6, 0, 0),  0, 0, 0, 0, 1, 0);
    set_v(9,  0, 32'd0,           0, 0, 0, 0, 1, 0);
    // youngest wins
    set_v(10, 1, r_add(5, 1, 2),  0, 0, 0, 0, 1, 0);
    set_v(11, 1, r_add(5, 1, 2),  0, 0, 0, 0, 1, 0);
    set_v(12, 1, s_sw(5, 5),      0, 0, 1, 1, 1, 0);
    set_v(13, 0, 32'd0,           0, 0, 0, 0, 1, 0);
    // redirect beats load-use stall; killed inst not inserted
    set_v(14, 1, i_lw(7, 1),      0, 0, 0, 0, 1, 0);
    set_v(15, 1, r_add(8, 7, 7),  1, 0, 1, 1, 1, 0);
    set_v(16, 1, r_add(9, 8, 8),  0, 0, 0, 0, 1, 1);
    // redirect without valid decode is not a flush
    set_v(17, 0, 32'd0,           1, 0, 0, 0, 1, 1);
    set_v(18, 0, 32'd0,           0, 0, 0, 0, 1, 1);

    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_sel1", 32'(bus.fwd_rs1_sel), 32'd0);
    chk("rst_sel2", 32'(bus.fwd_rs2_sel), 32'd0);
    chk("rst_stc", bus.stall_cycles, 32'd0);
    chk("rst_flc", bus.flush_cycles, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(vecs[k].valid, vecs[k].inst, vecs[k].redir);
      #2;
      chk($sformatf("v%0d_stall", k), 32'(bus.stall),
          32'(vecs[k].stall));
      chk($sformatf("v%0d_sel1", k), 32'(bus.fwd_rs1_sel),
          32'(vecs[k].s1));
      chk($sformatf("v%0d_sel2", k), 32'(bus.fwd_rs2_sel),
          32'(vecs[k].s2));
      chk($sformatf("v%0d_stc", k), bus.stall_cycles,
          32'(vecs[k].stc));
      chk($sformatf("v%0d_flc", k), bus.flush_cycles,
          32'(vecs[k].flc));
    end

    // async reset mid-stream with a load-use stall pending
    @(negedge clk);
    drive(1'b1, i_lw(5, 1), 1'b0);
    @(negedge clk);
    drive(1'b1, r_add(6, 5, 0), 1'b0);
    #1;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_sel1", 32'(bus.fwd_rs1_sel), 32'd0);
    chk("arst_stc", bus.stall_cycles, 32'd0);
    chk("arst_flc", bus.flush_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, r_add(6, 5, 0), 1'b0);
    #2;
    chk("post_rst_stall", 32'(bus.stall), 32'd0);
    chk("post_rst_sel1", 32'(bus.fwd_rs1_sel), 32'd0);
    @(negedge clk);
    drive(1'b0, 32'd0, 1'b0);
    #2;
    chk("post_rst_stc", bus.stall_cycles, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
